// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front-end.
//   fetch_state_t : fetch control state (RUN issues requests, DRAIN drops stale responses)
//   fetch_entry_t : prefetch FIFO entry {pc, instr}
//   INSTR_BYTES   : PC increment per fetched word
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle of the fetch unit.
//   imem_req_*     : word requests to instruction memory (valid/ready)
//   imem_rsp_*     : in-order responses, no backpressure
//   id_*           : instruction handed to decode (valid/ready)
//   redirect_*     : branch/jump/flush from later stages
// Modport master is the fetch unit side, slave is the memory/pipeline side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// sync_fifo: small synchronous FIFO with occupancy count and synchronous flush.
//   clk, reset (async, active-high)
//   flush            : empties the FIFO, has priority over push/pop
//   push, push_data  : write; accepted when not full or when popping in the same cycle
//   pop              : removes head when not empty
//   head_data        : current head entry (register read, stable until popped)
//   count            : number of valid entries (0..DEPTH)
// DEPTH must be a power of two, >= 2, so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == CNT_W'(0));
  assign do_push_s = push && (!full_s || pop);
  assign do_pop_s  = pop && !empty_s;
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; entries reset to zero so the head reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front-end. Owns the PC, issues word requests to instruction
// memory, buffers responses in a prefetch FIFO and hands them to decode.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : instr_fetch_unit_if.master (imem request/response, decode handoff, redirect)
// Optional feature: define INSTR_FETCH_BYPASS_EN to present a response on id_* in the
// cycle it arrives when the prefetch FIFO is empty (otherwise id_* is fully registered).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_r, state_next_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [CNT_W-1:0]  discard_r, discard_next_s;
  logic              req_valid_r, req_valid_next_s;

  logic              req_fire_s, rsp_run_s, bypass_s, bypass_take_s, id_valid_s;
  logic              pf_push_s, pf_pop_s, pf_empty_s;
  logic [CNT_W-1:0]  pf_count_s, pq_count_s, outstanding_s;
  logic [CNT_W-1:0]  pf_count_next_s, pq_count_next_s;
  logic [CNT_W:0]    credit_next_s;
  fetch_entry_t      pf_wdata_s, pf_head_s;
  logic [ADDR_W-1:0] pq_head_s;

  assign req_fire_s    = req_valid_r && bus.imem_req_ready;
  assign rsp_run_s     = bus.imem_rsp_valid && (state_r == RUN);
  assign pf_empty_s    = (pf_count_s == CNT_W'(0));
`ifdef INSTR_FETCH_BYPASS_EN
  assign bypass_s      = pf_empty_s && rsp_run_s;
`else
  assign bypass_s      = 1'b0;
`endif
  assign bypass_take_s = bypass_s && bus.id_ready;
  assign id_valid_s    = !pf_empty_s || bypass_s;
  assign pf_push_s     = rsp_run_s && !bypass_take_s;
  assign pf_pop_s      = bus.id_ready && !pf_empty_s;
  // In DRAIN the pending queue is already flushed; the stale count lives in discard_r.
  assign outstanding_s = (state_r == RUN) ? pq_count_s : discard_r;
  assign pf_wdata_s    = '{pc: FETCH_ADDR_W'(pq_head_s), instr: FETCH_DATA_W'(bus.imem_rsp_data)};

  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_req_addr  = pc_r;
  assign bus.id_valid       = id_valid_s;
  assign bus.id_instr       = bypass_s ? bus.imem_rsp_data : DATA_W'(pf_head_s.instr);
  assign bus.id_pc          = bypass_s ? pq_head_s : ADDR_W'(pf_head_s.pc);

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (pf_push_s),
    .push_data (pf_wdata_s),
    .pop       (pf_pop_s),
    .head_data (pf_head_s),
    .count     (pf_count_s)
  );

  // Addresses of accepted requests, popped in order as responses return.
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_pending (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (rsp_run_s),
    .head_data (pq_head_s),
    .count     (pq_count_s)
  );

  // Next state, PC and stale-response count.
  always_comb begin
    state_next_s   = state_r;
    pc_next_s      = pc_r;
    discard_next_s = discard_r;
    if (bus.redirect_valid) begin
      pc_next_s      = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      discard_next_s = outstanding_s + CNT_W'(req_fire_s) - CNT_W'(bus.imem_rsp_valid);
      if (discard_next_s != CNT_W'(0)) begin
        state_next_s = DRAIN;
      end else begin
        state_next_s = RUN;
      end
    end else begin
      if (req_fire_s) begin
        pc_next_s = pc_r + ADDR_W'(INSTR_BYTES);
      end else begin
        pc_next_s = pc_r;
      end
      case (state_r)
        RUN: begin
          state_next_s = RUN;
        end
        DRAIN: begin
          if (bus.imem_rsp_valid) begin
            discard_next_s = discard_r - CNT_W'(1);
            state_next_s   = (discard_r == CNT_W'(1)) ? RUN : DRAIN;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: begin
          state_next_s = RUN;
        end
      endcase
    end
  end

  // Request valid for the next cycle, from the occupancies the FIFOs will hold then.
  always_comb begin
    pf_count_next_s  = '0;
    pq_count_next_s  = '0;
    if (bus.redirect_valid) begin
      pf_count_next_s = '0;
      pq_count_next_s = '0;
    end else begin
      pf_count_next_s = pf_count_s + CNT_W'(pf_push_s) - CNT_W'(pf_pop_s);
      pq_count_next_s = pq_count_s + CNT_W'(req_fire_s) - CNT_W'(rsp_run_s);
    end
    credit_next_s    = {1'b0, pf_count_next_s} + {1'b0, pq_count_next_s};
    req_valid_next_s = (state_next_s == RUN) && (credit_next_s < (CNT_W+1)'(FIFO_DEPTH));
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      discard_r   <= '0;
      req_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      discard_r   <= discard_next_s;
      req_valid_r <= req_valid_next_s;
    end
  end
endmodule
